// File: rtl/wm8731_ctrl_pkg.sv
// Shared constants for the WM8731 control-port receiver: register map,
// register-file size and power-on defaults of the codec registers.
package wm8731_ctrl_pkg;

    localparam int NUM_REGS = 10;

    localparam logic [6:0] R0 = 7'h00;
    localparam logic [6:0] R1 = 7'h01;
    localparam logic [6:0] R2 = 7'h02;
    localparam logic [6:0] R3 = 7'h03;
    localparam logic [6:0] R4 = 7'h04;
    localparam logic [6:0] R5 = 7'h05;
    localparam logic [6:0] R6 = 7'h06;
    localparam logic [6:0] R7 = 7'h07;
    localparam logic [6:0] R8 = 7'h08;
    localparam logic [6:0] R9 = 7'h09;
    localparam logic [6:0] RESET_ADDR = 7'h0F;

    // Index [0] is R0, index [9] is R9.
    localparam logic [NUM_REGS-1:0][8:0] REG_DEFAULTS = {
        9'h000, 9'h000, 9'h00A, 9'h09F, 9'h008,
        9'h00A, 9'h079, 9'h079, 9'h097, 9'h097
    };

    function automatic logic is_reg_addr(input logic [6:0] addr);
        return addr <= R9;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser plus history flop for one asynchronous input,
// with rise/fall strobes taken from the last two stages.
module sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
            s3_q <= RST_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign level_o = s2_q;
    assign rise_o  = s2_q & ~s3_q;
    assign fall_o  = ~s2_q & s3_q;

endmodule

// File: rtl/wm8731_ctrl_rx.sv
// WM8731 3-wire control-port receiver: deserialises 16-bit words framed by
// CSB rising edges and mirrors them into a shadow copy of the codec registers.
module wm8731_ctrl_rx #(
    parameter int MIN_HALF = 3
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       CSB,
    input  logic       SCLK,
    input  logic       SDIN,
    output logic       word_valid,
    output logic [6:0] word_addr,
    output logic [8:0] word_data,
    output logic       frame_err,
    output logic       addr_err,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       codec_active
);

    import wm8731_ctrl_pkg::*;

    // SCLK timing limits concern the driving side only.
    localparam int unused_min_half = MIN_HALF;

    logic csb_rise, sclk_rise, sdin_s;
    logic csb_level_unused, csb_fall_unused;
    logic sclk_level_unused, sclk_fall_unused;
    logic sdin_rise_unused, sdin_fall_unused;

    sync_edge #(.RST_VAL(1'b1)) u_sync_csb (
        .clk_i(clk_50M), .rst_ni(rst_n), .d_i(CSB),
        .level_o(csb_level_unused), .rise_o(csb_rise), .fall_o(csb_fall_unused)
    );

    sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk_i(clk_50M), .rst_ni(rst_n), .d_i(SCLK),
        .level_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall_unused)
    );

    sync_edge #(.RST_VAL(1'b0)) u_sync_sdin (
        .clk_i(clk_50M), .rst_ni(rst_n), .d_i(SDIN),
        .level_o(sdin_s), .rise_o(sdin_rise_unused), .fall_o(sdin_fall_unused)
    );

    logic [15:0]                  shreg_q, shreg_d, shreg_sh;
    logic [4:0]                   bitcnt_q, bitcnt_d, bitcnt_sh;
    logic [NUM_REGS-1:0][8:0]     regs_q, regs_d;
    logic [6:0]                   word_addr_q, word_addr_d;
    logic [8:0]                   word_data_q, word_data_d;
    logic                         word_valid_q, word_valid_d;
    logic                         frame_err_q, frame_err_d;
    logic                         addr_err_q, addr_err_d;

    // A same-cycle SCLK and CSB rise commits the already-shifted word.
    always_comb begin
        shreg_sh  = sclk_rise ? {shreg_q[14:0], sdin_s} : shreg_q;
        bitcnt_sh = (sclk_rise && bitcnt_q != 5'd16) ? bitcnt_q + 5'd1 : bitcnt_q;

        shreg_d      = shreg_sh;
        bitcnt_d     = bitcnt_sh;
        regs_d       = regs_q;
        word_addr_d  = word_addr_q;
        word_data_d  = word_data_q;
        word_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        addr_err_d   = 1'b0;

        if (csb_rise) begin
            bitcnt_d = '0;
            if (bitcnt_sh == 5'd16) begin
                word_valid_d = 1'b1;
                word_addr_d  = shreg_sh[15:9];
                word_data_d  = shreg_sh[8:0];
                if (is_reg_addr(shreg_sh[15:9])) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (shreg_sh[12:9] == 4'(i)) begin
                            regs_d[i] = shreg_sh[8:0];
                        end
                    end
                end else if (shreg_sh[15:9] == RESET_ADDR) begin
                    regs_d = REG_DEFAULTS;
                end else begin
                    addr_err_d = 1'b1;
                end
            end else begin
                frame_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            regs_q       <= REG_DEFAULTS;
            word_addr_q  <= '0;
            word_data_q  <= '0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            shreg_q      <= shreg_d;
            bitcnt_q     <= bitcnt_d;
            regs_q       <= regs_d;
            word_addr_q  <= word_addr_d;
            word_data_q  <= word_data_d;
            word_valid_q <= word_valid_d;
            frame_err_q  <= frame_err_d;
            addr_err_q   <= addr_err_d;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == 4'(i)) begin
                rd_data = regs_q[i];
            end
        end
    end

    assign word_valid   = word_valid_q;
    assign word_addr    = word_addr_q;
    assign word_data    = word_data_q;
    assign frame_err    = frame_err_q;
    assign addr_err     = addr_err_q;
    assign codec_active = regs_q[NUM_REGS-1][0];

endmodule
